// File: rtl/io_access_master.sv
// Single-outstanding IO bus master: takes one CPU access at a time, drives the IO map
// handshake and reports completion, bad address or responder timeout back to the CPU.
module io_access_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [27:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [31:0] io_mem_data_wr,
    output logic [27:0] io_mem_data_addr,
    output logic        io_mem_rw_data,
    output logic        io_mem_valid_data,
    input  logic [31:0] io_mem_data_rd,
    input  logic        io_mem_ready_data
);

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_DONE, S_ERR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        busy_nxt, done_nxt, err_nxt, valid_nxt, rw_nxt;
    logic [31:0] rdata_nxt, wr_nxt;
    logic [27:0] addr_nxt;
    logic        addr_ok, accept, expire;

    assign addr_ok = (cpu_addr >= 28'h8000000) && (cpu_addr <= 28'h8000006);
    // A ready seen in the first REQ cycle may be left over from a previous access.
    assign accept  = (state == S_REQ) && (cnt != 8'd0) && io_mem_ready_data;
    assign expire  = (state == S_REQ) && !accept && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cpu_req) state_nxt = addr_ok ? S_REQ : S_ERR;
            S_REQ:   if (accept) state_nxt = S_REL;
                     else if (expire) state_nxt = S_ERR;
            S_REL:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt   = cnt;
        busy_nxt  = cpu_busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = cpu_rdata;
        valid_nxt = io_mem_valid_data;
        rw_nxt    = io_mem_rw_data;
        addr_nxt  = io_mem_data_addr;
        wr_nxt    = io_mem_data_wr;
        case (state)
            S_IDLE: if (cpu_req) begin
                busy_nxt  = 1'b1;
                rw_nxt    = cpu_we;
                addr_nxt  = cpu_addr;
                wr_nxt    = cpu_wdata;
                valid_nxt = addr_ok;
                err_nxt   = !addr_ok;
                cnt_nxt   = 8'd0;
            end
            S_REQ: begin
                if (accept) begin
                    if (!io_mem_rw_data) rdata_nxt = io_mem_data_rd;
                end else if (expire) begin
                    valid_nxt = 1'b0;
                    rdata_nxt = 32'hFFFF_FFFF;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            // valid stays up through REL so the responder sees the handshake and drops ready
            S_REL: begin
                valid_nxt = 1'b0;
                done_nxt  = 1'b1;
            end
            S_DONE, S_ERR: busy_nxt = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt               <= '0;
            cpu_busy          <= 1'b0;
            cpu_done          <= 1'b0;
            cpu_err           <= 1'b0;
            cpu_rdata         <= '0;
            io_mem_valid_data <= 1'b0;
            io_mem_rw_data    <= 1'b0;
            io_mem_data_addr  <= '0;
            io_mem_data_wr    <= '0;
        end else begin
            cnt               <= cnt_nxt;
            cpu_busy          <= busy_nxt;
            cpu_done          <= done_nxt;
            cpu_err           <= err_nxt;
            cpu_rdata         <= rdata_nxt;
            io_mem_valid_data <= valid_nxt;
            io_mem_rw_data    <= rw_nxt;
            io_mem_data_addr  <= addr_nxt;
            io_mem_data_wr    <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_io_access_master.sv
// Random access bench for io_access_master: outcome, latency, valid length and read data
// are predicted from the access rules, not from the state machine.
module tb_io_access_master;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [27:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [31:0] cpu_rdata, io_mem_data_wr;
    logic [27:0] io_mem_data_addr;
    logic        io_mem_rw_data, io_mem_valid_data;
    logic [31:0] io_mem_data_rd = '0;
    logic        io_mem_ready_data = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_rdata = '0;

    io_access_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .io_mem_data_wr(io_mem_data_wr), .io_mem_data_addr(io_mem_data_addr),
        .io_mem_rw_data(io_mem_rw_data), .io_mem_valid_data(io_mem_valid_data),
        .io_mem_data_rd(io_mem_data_rd), .io_mem_ready_data(io_mem_ready_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_io"}, {2'b0, io_mem_valid_data, io_mem_rw_data, io_mem_data_addr, io_mem_data_wr}, 64'd0);
        chk({tag, "_cpu"}, {cpu_busy, cpu_done, cpu_err, cpu_rdata}, 64'd0);
    endtask

    // rdy_at: index of the valid cycle in which the responder raises ready (0 = never).
    // stale: ready already high when the request is issued and through valid cycle 1.
    // sticky: cpu_req kept high for the whole access, which must not start a second one.
    task automatic access(input logic we, input logic [27:0] addr, input logic [31:0] wd,
                          input int rdy_at, input bit stale, input bit sticky, input logic [31:0] rdv);
        int n = 0, vcnt = 0, dcnt = 0, ecnt = 0, done_at = -1, err_at = -1;
        int unstable = 0, busy_lo = 0;
        bit fin = 0, ok;
        logic [31:0] rd_acc = '0;
        ok = (addr >= 28'h8000000) && (addr <= 28'h8000006);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        io_mem_ready_data = stale;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(negedge clk);
            if (!sticky) cpu_req = 1'b0;
            cpu_we = 1'($urandom); cpu_addr = 28'($urandom); cpu_wdata = $urandom;
            if (!cpu_busy) busy_lo++;
            if (io_mem_data_addr !== addr || io_mem_data_wr !== wd || io_mem_rw_data !== we)
                unstable++;
            if (io_mem_valid_data) begin n++; vcnt++; end
            io_mem_ready_data = io_mem_valid_data && ((stale && n == 1) || n == rdy_at);
            io_mem_data_rd = (io_mem_valid_data && n == rdy_at) ? rdv : $urandom;
            if (io_mem_ready_data) rd_acc = io_mem_data_rd;
            if (cpu_done) begin dcnt++; done_at = cyc; end
            if (cpu_err) begin ecnt++; err_at = cyc; end
            if (cpu_done || cpu_err) begin cpu_req = 1'b0; fin = 1; end
        end
        chk("finished", 64'(fin), 64'd1);
        chk("busy_held", 64'(busy_lo), 64'd0);
        chk("fields_stable", 64'(unstable), 64'd0);
        if (!ok) begin
            chk("outcome", {dcnt[31:0], ecnt[31:0]}, {32'd0, 32'd1});
            chk("latency", 64'(err_at), 64'd1);
            chk("valid_cycles", 64'(vcnt), 64'd0);
        end else if (rdy_at >= 2 && rdy_at <= TO) begin
            if (!we) exp_rdata = rd_acc;
            chk("outcome", {dcnt[31:0], ecnt[31:0]}, {32'd1, 32'd0});
            chk("latency", 64'(done_at), 64'(rdy_at + 2));
            chk("valid_cycles", 64'(vcnt), 64'(rdy_at + 1));
        end else begin
            exp_rdata = 32'hFFFF_FFFF;
            chk("outcome", {dcnt[31:0], ecnt[31:0]}, {32'd0, 32'd1});
            chk("latency", 64'(err_at), 64'(TO + 1));
            chk("valid_cycles", 64'(vcnt), 64'(TO));
        end
        chk("rdata", 64'(cpu_rdata), 64'(exp_rdata));
        @(negedge clk);
        io_mem_ready_data = 1'b0;
        chk("after_end", {cpu_busy, cpu_done, cpu_err, io_mem_valid_data}, 64'd0);
        @(negedge clk);
        chk("not_queued", {cpu_busy, io_mem_valid_data}, 64'd0);
        chk("rdata_hold", 64'(cpu_rdata), 64'(exp_rdata));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        access(1'b0, 28'h8000006, 32'h0, 2, 0, 0, 32'h0000_0123);
        chk("directed_read", 64'(cpu_rdata), 64'h123);
        access(1'b1, 28'h8000004, 32'h0ABC_DEF0, 3, 0, 1, 32'h5555_5555);
        chk("write_keeps_rdata", 64'(cpu_rdata), 64'h123);
        access(1'b0, 28'h8000001, 32'h0, 3, 1, 0, 32'hCAFE_0001);
        access(1'b0, 28'h8000002, 32'h0, 1, 1, 0, 32'h1);
        access(1'b0, 28'h8000000, 32'h0, TO, 0, 0, 32'hBEEF_0008);
        access(1'b0, 28'h8000003, 32'h0, 0, 0, 0, 32'h1);
        access(1'b1, 28'h8000007, 32'h1234, 2, 0, 0, 32'h1);
        access(1'b0, 28'h7FFFFFF, 32'h0, 2, 0, 1, 32'h1);

        // reset while the master is in its release cycle
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 28'h8000003;
        @(negedge clk); cpu_req = 1'b0; io_mem_ready_data = 1'b0;
        @(negedge clk); io_mem_ready_data = 1'b1; io_mem_data_rd = 32'h77;
        @(negedge clk); io_mem_ready_data = 1'b0;
        chk("in_release", {cpu_busy, io_mem_valid_data, cpu_done}, 64'b110);
        #1 rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        exp_rdata = '0;
        @(negedge clk); rst_n = 1'b1;
        access(1'b0, 28'h8000005, 32'h0, 3, 0, 0, 32'h0BAD_F00D);

        for (int i = 0; i < 30; i++) begin
            logic [27:0] a;
            a = ($urandom_range(0, 3) == 0) ? 28'($urandom) : 28'h7FFFFFF + 28'($urandom_range(0, 8));
            access(1'($urandom), a, $urandom, int'($urandom_range(0, TO + 2)),
                   1'($urandom), 1'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_access_master.md
IO_ACCESS_MASTER -- requirements
Module: io_access_master

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the max REQ-state cycles waited for io_mem_ready_data before aborting (range 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset SHALL be asynchronous and active-low.
REQ-004 cpu_req  input  1  CPU requests an IO access; sampled only when cpu_busy=0.
REQ-005 cpu_we  input  1  1=write, 0=read.
REQ-006 cpu_addr  input  28  IO word address.
REQ-007 cpu_wdata  input  32  write data.
REQ-008 cpu_busy  output  1  access in progress; CPU SHALL hold its pipeline.
REQ-009 cpu_done  output  1  one-cycle completion pulse.
REQ-010 cpu_err  output  1  one-cycle error pulse (bad address or timeout); never coincident with cpu_done.
REQ-011 cpu_rdata  output  32  read result; held until next accepted request.
REQ-012 io_mem_data_wr  output  32  write data to IO map.
REQ-013 io_mem_data_addr  output  28  address to IO map.
REQ-014 io_mem_rw_data  output  1  1=write.
REQ-015 io_mem_valid_data  output  1  request valid.
REQ-016 io_mem_data_rd  input  32  read data from IO map.
REQ-017 io_mem_ready_data  input  1  responder ready.

Function
REQ-018 States SHALL be IDLE, REQ, REL, DONE, ERR; all outputs registered.
REQ-019 IDLE, cpu_req=1: latch cpu_we/cpu_addr/cpu_wdata into io_mem_rw_data/io_mem_data_addr/io_mem_data_wr and cpu_busy<=1; cpu_addr in 0x8000000..0x8000006 -> REQ with io_mem_valid_data<=1; else -> ERR, valid stays 0.
REQ-020 Latched request fields SHALL stay stable from IDLE exit until return to IDLE.
REQ-021 REQ: valid=1; timeout counter SHALL start at 0 on entry and increment per REQ cycle.
REQ-022 io_mem_ready_data SHALL be ignored in the first REQ cycle (stale-ready guard); completion accepted from the second REQ cycle on.
REQ-023 REQ, io_mem_ready_data=1 (accepted): read -> cpu_rdata<=io_mem_data_rd that edge; write -> cpu_rdata unchanged; -> REL.
REQ-024 REL: exactly one cycle, io_mem_valid_data held 1 so responder sees valid&ready and drops ready; valid<=0 at REL exit; -> DONE.
REQ-025 DONE: cpu_done=1, cpu_busy<=0 at exit; -> IDLE; new cpu_req accepted in the following IDLE cycle (min 5 cycles per access, request to done).
REQ-026 REQ, counter reaches TIMEOUT-1 with ready=0 that cycle: valid<=0, cpu_rdata<=32'hFFFFFFFF, -> ERR.
REQ-027 Ready and timeout in the same cycle: ready SHALL win (REL path).
REQ-028 ERR: cpu_err=1 one cycle, cpu_busy<=0 at exit, -> IDLE.
REQ-029 cpu_req while cpu_busy=1 SHALL be ignored (not queued).
REQ-030 io_mem_data_rd SHALL be ignored outside REQ-accept edge.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, counter 0, and all outputs (io_mem_*, cpu_busy, cpu_done, cpu_err, cpu_rdata) to 0, including mid-access.
REQ-032 First cpu_req SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-033 Read 0x8000006, responder ready on 2nd REQ cycle with rd=0x00000123 -> cpu_rdata=0x00000123, cpu_done one cycle, valid high exactly 3 cycles.
REQ-034 Write 0x8000004 data 0x0ABCDEF0 -> io_mem_rw_data=1, addr/data stable throughout, cpu_done pulse, cpu_rdata unchanged.
REQ-035 Ready held 1 before and during first REQ cycle, dropped after -> access not completed on stale ready; completes on next genuine ready.
REQ-036 TIMEOUT=8, responder never ready -> valid drops after 8 REQ cycles, cpu_err pulse, cpu_rdata=0xFFFFFFFF, no cpu_done.
REQ-037 cpu_addr=0x8000007 -> cpu_err after 2 cycles, io_mem_valid_data never asserted.
REQ-038 rst_n low during REL -> all outputs 0 immediately; after release, new read to 0x8000005 completes normally.
